// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types for the frog-game rule controller:
//   game_state_e : top-level game FSM states
//   hit_class_e  : what the player is touching on the current pixel
//   SEL_BG       : select_mux code for the background layer
//   clog2_min1() : $clog2 that never returns 0, used to size index/counter
//                  fields so degenerate parameter values still give legal
//                  vector widths
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_PLAY = 3'd0,
        ST_WIN  = 3'd1,
        ST_LOSE = 3'd2,
        ST_BUZ  = 3'd3,
        ST_OVER = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        HIT_NONE   = 2'd0,
        HIT_HAZARD = 2'd1,
        HIT_GOAL   = 2'd2,
        HIT_GATE   = 2'd3
    } hit_class_e;

    localparam int SEL_BG = 0;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_rules_ctrl_buzz_timer.sv
// -----------------------------------------------------------------------------
// buzz_timer
// Down-counter that times the sound burst.
//   clk, resetN : clock, asynchronous active-low reset
//   load        : load load_val (takes priority over hold)
//   hold        : freeze the count
//   load_val    : value loaded on load
//   done        : count is zero
// The count stops at zero instead of wrapping.
// -----------------------------------------------------------------------------
module buzz_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Load, hold or count down towards zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (!hold && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    assign done = (cnt_r == '0);

endmodule

// File: rtl/game_rules_ctrl.sv
// -----------------------------------------------------------------------------
// game_rules_ctrl
// Game-rule FSM for the VGA frog game. Picks the drawn layer per pixel
// (object 0 highest priority, then player, then background), turns player
// overlaps into lose / win / gate events and tracks level, lives, lane mask
// and a timed sound burst.
// Ports:
//   clk, resetN      clock, asynchronous active-low reset
//   obj_draw_req     per-object draw request for the current pixel
//   player_draw_req  frog draw request
//   hazard/goal/gate_mask  static object classes (checked in that order)
//   frame_start      frame pulse, re-arms the gate
//   start            restart pulse, only honoured in game over
//   pause            freeze request (GAME_PAUSE_EN builds only)
//   select_mux       0 bg, i+1 object i, NUM_OBJ+1 player (combinational)
//   win/lose/take_gate/gate_id  one-cycle event pulses
//   enable_sound, sound_freq    burst enable and tone
//   level, lives, lane_enable, game_over  game status
// Build option: define GAME_PAUSE_EN to enable the pause input.
// -----------------------------------------------------------------------------
module game_rules_ctrl
    import game_pkg::*;
#(
    parameter int NUM_OBJ    = 8,
    parameter int LEVEL_W    = 8,
    parameter int MAX_LEVEL  = 8,
    parameter int LIVES      = 3,
    parameter int LANE_W     = 15,
    parameter int LANE_STEP  = 5,
    parameter int BUZ_CYCLES = 50000000,
    parameter int FREQ_W     = 10,
    parameter int WIN_FREQ   = 500,
    parameter int LOSE_FREQ  = 950
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic [NUM_OBJ-1:0]                obj_draw_req,
    input  logic                              player_draw_req,
    input  logic [NUM_OBJ-1:0]                hazard_mask,
    input  logic [NUM_OBJ-1:0]                goal_mask,
    input  logic [NUM_OBJ-1:0]                gate_mask,
    input  logic                              frame_start,
    input  logic                              start,
    input  logic                              pause,
    output logic [$clog2(NUM_OBJ+2)-1:0]      select_mux,
    output logic                              win,
    output logic                              lose,
    output logic                              take_gate,
    output logic [clog2_min1(NUM_OBJ)-1:0]    gate_id,
    output logic                              enable_sound,
    output logic [FREQ_W-1:0]                 sound_freq,
    output logic [LEVEL_W-1:0]                level,
    output logic [3:0]                        lives,
    output logic [LANE_W-1:0]                 lane_enable,
    output logic                              game_over
);

    localparam int SEL_W = $clog2(NUM_OBJ + 2);
    localparam int GID_W = clog2_min1(NUM_OBJ);
    localparam int CNT_W = clog2_min1(BUZ_CYCLES);

    localparam logic [LEVEL_W-1:0] LEVEL_MIN  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [LANE_W-1:0]  LANE_FILL  = LANE_W'((64'd1 << LANE_STEP) - 64'd1);

    logic             pause_s;
    logic             obj_any_s;
    logic [GID_W-1:0] win_idx_s;
    logic [SEL_W-1:0] select_mux_s;
    hit_class_e       hit_s;
    logic             buz_load_s;
    logic             buz_hold_s;
    logic             buz_done_s;

    game_state_e       state_r;
    logic [LEVEL_W-1:0] level_r;
    logic [3:0]         lives_r;
    logic [LANE_W-1:0]  lane_r;
    logic [FREQ_W-1:0]  freq_r;
    logic               armed_r;
    logic               win_r;
    logic               lose_r;
    logic               take_gate_r;
    logic [GID_W-1:0]   gate_id_r;
    logic               buz_r;
    logic               over_r;

`ifdef GAME_PAUSE_EN
    assign pause_s = pause;
`else
    // Pause is accepted but has no effect in this build.
    assign pause_s = pause & 1'b0;
`endif

    // Lowest asserted object index wins; scanning downwards lets lower
    // indices overwrite higher ones.
    always_comb begin
        win_idx_s = '0;
        obj_any_s = |obj_draw_req;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            win_idx_s = obj_draw_req[i] ? GID_W'(i) : win_idx_s;
        end
    end

    // Layer select: winning object, else player, else background.
    always_comb begin
        select_mux_s = SEL_W'(SEL_BG);
        if (obj_any_s) begin
            select_mux_s = SEL_W'(win_idx_s) + SEL_W'(1);
        end else if (player_draw_req) begin
            select_mux_s = SEL_W'(NUM_OBJ + 1);
        end else begin
            select_mux_s = SEL_W'(SEL_BG);
        end
    end

    // Classify the overlap; an object in several masks takes the first match.
    always_comb begin
        hit_s = HIT_NONE;
        if (player_draw_req && obj_any_s) begin
            if (hazard_mask[win_idx_s]) begin
                hit_s = HIT_HAZARD;
            end else if (goal_mask[win_idx_s]) begin
                hit_s = HIT_GOAL;
            end else if (gate_mask[win_idx_s]) begin
                hit_s = HIT_GATE;
            end else begin
                hit_s = HIT_NONE;
            end
        end else begin
            hit_s = HIT_NONE;
        end
    end

    // The burst counter is loaded in the one-cycle WIN/LOSE state so it holds
    // BUZ_CYCLES-1 on BUZ entry and reaches zero on the last burst cycle.
    assign buz_load_s = !pause_s &&
                        ((state_r == ST_WIN) || ((state_r == ST_LOSE) && (lives_r != 4'd0)));
    assign buz_hold_s = pause_s || (state_r != ST_BUZ);

    buzz_timer #(
        .CNT_W (CNT_W)
    ) u_buzz_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (buz_load_s),
        .hold     (buz_hold_s),
        .load_val (CNT_W'(BUZ_CYCLES - 1)),
        .done     (buz_done_s)
    );

    // Game FSM. Status updates are applied on the edge that enters WIN/LOSE so
    // the new level/lives/lanes are visible together with the event pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ST_PLAY;
            level_r     <= LEVEL_MIN;
            lives_r     <= LIVES_INIT;
            lane_r      <= '0;
            freq_r      <= '0;
            armed_r     <= 1'b1;
            win_r       <= 1'b0;
            lose_r      <= 1'b0;
            take_gate_r <= 1'b0;
            gate_id_r   <= '0;
            buz_r       <= 1'b0;
            over_r      <= 1'b0;
        end else if (!pause_s) begin
            win_r       <= 1'b0;
            lose_r      <= 1'b0;
            take_gate_r <= 1'b0;
            if (frame_start) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                ST_PLAY: begin
                    case (hit_s)
                        HIT_HAZARD: begin
                            state_r <= ST_LOSE;
                            lose_r  <= 1'b1;
                            freq_r  <= FREQ_W'(LOSE_FREQ);
                            lives_r <= lives_r - 4'd1;
                            level_r <= (level_r > LEVEL_MIN) ? level_r - LEVEL_W'(1) : LEVEL_MIN;
                            lane_r  <= lane_r >> LANE_STEP;
                        end
                        HIT_GOAL: begin
                            state_r <= ST_WIN;
                            win_r   <= 1'b1;
                            freq_r  <= FREQ_W'(WIN_FREQ);
                            level_r <= (level_r < LEVEL_MAX) ? level_r + LEVEL_W'(1) : LEVEL_MAX;
                            lane_r  <= (lane_r << LANE_STEP) | LANE_FILL;
                        end
                        HIT_GATE: begin
                            // A gate hit wins over a same-cycle frame_start re-arm.
                            if (armed_r) begin
                                take_gate_r <= 1'b1;
                                gate_id_r   <= win_idx_s;
                                armed_r     <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                ST_LOSE: begin
                    if (lives_r == 4'd0) begin
                        state_r <= ST_OVER;
                        over_r  <= 1'b1;
                    end else begin
                        state_r <= ST_BUZ;
                        buz_r   <= 1'b1;
                    end
                end
                ST_WIN: begin
                    state_r <= ST_BUZ;
                    buz_r   <= 1'b1;
                end
                ST_BUZ: begin
                    if (buz_done_s) begin
                        state_r <= ST_PLAY;
                        buz_r   <= 1'b0;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        over_r  <= 1'b0;
                        level_r <= LEVEL_MIN;
                        lives_r <= LIVES_INIT;
                        lane_r  <= '0;
                    end
                end
                default: begin
                    state_r <= ST_PLAY;
                    buz_r   <= 1'b0;
                    over_r  <= 1'b0;
                end
            endcase
        end
    end

    assign select_mux   = select_mux_s;
    assign win          = win_r;
    assign lose         = lose_r;
    assign take_gate    = take_gate_r;
    assign gate_id      = gate_id_r;
    assign enable_sound = buz_r & ~pause_s;
    assign sound_freq   = freq_r;
    assign level        = level_r;
    assign lives        = lives_r;
    assign lane_enable  = lane_r;
    assign game_over    = over_r;

endmodule

// File: tb/tb_game_rules_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_rules_ctrl
// Self-checking bench for game_rules_ctrl (BUZ_CYCLES = 5).
// Event pulses are checked through an expected-event queue; status outputs
// are checked against a small game model kept by the bench.
// -----------------------------------------------------------------------------
module tb_game_rules_ctrl;

    localparam int BUZ = 5;

    logic        clk;
    logic        resetN;
    logic [7:0]  obj_draw_req;
    logic        player_draw_req;
    logic [7:0]  hazard_mask;
    logic [7:0]  goal_mask;
    logic [7:0]  gate_mask;
    logic        frame_start;
    logic        start;
    logic        pause;
    logic [3:0]  select_mux;
    logic        win;
    logic        lose;
    logic        take_gate;
    logic [2:0]  gate_id;
    logic        enable_sound;
    logic [9:0]  sound_freq;
    logic [7:0]  level;
    logic [3:0]  lives;
    logic [14:0] lane_enable;
    logic        game_over;

    game_rules_ctrl #(.BUZ_CYCLES(BUZ)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .obj_draw_req    (obj_draw_req),
        .player_draw_req (player_draw_req),
        .hazard_mask     (hazard_mask),
        .goal_mask       (goal_mask),
        .gate_mask       (gate_mask),
        .frame_start     (frame_start),
        .start           (start),
        .pause           (pause),
        .select_mux      (select_mux),
        .win             (win),
        .lose            (lose),
        .take_gate       (take_gate),
        .gate_id         (gate_id),
        .enable_sound    (enable_sound),
        .sound_freq      (sound_freq),
        .level           (level),
        .lives           (lives),
        .lane_enable     (lane_enable),
        .game_over       (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected event: flags = {win, lose, take_gate}
    typedef struct {
        logic [2:0] flags;
        logic [2:0] gid;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [7:0] obj;
        logic       pl;
        logic [7:0] hz;
        logic [7:0] gl;
        logic [7:0] gt;
        logic [3:0] sel;
        logic [2:0] ev;
        logic [2:0] gid;
    } vec_t;
    vec_t vecs[10];

    int level_m, lives_m, lane_m, freq_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every event pulse must match the oldest expected event.
    always @(negedge clk) begin : mon
        ev_t e;
        if (win || lose || take_gate) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: got win=%0b lose=%0b take_gate=%0b, required none",
                         win, lose, take_gate);
            end else begin
                e = exp_q.pop_front();
                chk("event_flags", {29'd0, win, lose, take_gate}, {29'd0, e.flags});
                if (e.flags[0]) chk("gate_id", {29'd0, gate_id}, {29'd0, e.gid});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        obj_draw_req    = 8'h00;
        player_draw_req = 1'b0;
        hazard_mask     = 8'h00;
        goal_mask       = 8'h00;
        gate_mask       = 8'h00;
        frame_start     = 1'b0;
        start           = 1'b0;
    endtask

    task automatic model_reset;
        level_m = 1;
        lives_m = 3;
        lane_m  = 0;
        freq_m  = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, {24'd0, level}, 32'd1);
        chk({tag, "_lives"}, {28'd0, lives}, 32'd3);
        chk({tag, "_lane"}, {17'd0, lane_enable}, 32'd0);
        chk({tag, "_freq"}, {22'd0, sound_freq}, 32'd0);
        chk({tag, "_sound"}, {31'd0, enable_sound}, 32'd0);
        chk({tag, "_pulses"}, {29'd0, win, lose, take_gate}, 32'd0);
        chk({tag, "_over"}, {31'd0, game_over}, 32'd0);
    endtask

    task automatic do_reset;
        clear_in();
        resetN = 1'b0;
        #1;
        chk_reset_vals("reset");
        step();
        resetN = 1'b1;
        model_reset();
        step();
    endtask

    // Count the burst length from the WIN/LOSE state until back in PLAY.
    task automatic run_buz;
        int hi;
        int guard;
        hi = 0;
        guard = 0;
        while (!enable_sound && guard < 20) begin
            step();
            guard++;
        end
        while (enable_sound && guard < 60) begin
            hi++;
            step();
            guard++;
        end
        chk("buz_length", hi, BUZ);
    endtask

    // Player hits object idx, which is a goal (is_win) or a hazard.
    task automatic do_event(input bit is_win, input int idx);
        logic [7:0] b;
        ev_t e;
        b = 8'd1 << idx;
        obj_draw_req    = b;
        player_draw_req = 1'b1;
        if (is_win) goal_mask = b;
        else hazard_mask = b;
        #1;
        chk("hit_select_mux", {28'd0, select_mux}, idx + 1);
        e.gid = 3'd0;
        if (is_win) begin
            e.flags = 3'b100;
            level_m = (level_m < 8) ? level_m + 1 : 8;
            lane_m  = ((lane_m << 5) | 32'h1F) & 32'h7FFF;
            freq_m  = 500;
        end else begin
            e.flags = 3'b010;
            lives_m = lives_m - 1;
            level_m = (level_m > 1) ? level_m - 1 : 1;
            lane_m  = lane_m >> 5;
            freq_m  = 950;
        end
        exp_q.push_back(e);
        step();
        clear_in();
        chk("ev_level", {24'd0, level}, level_m);
        chk("ev_lives", {28'd0, lives}, lives_m);
        chk("ev_lane", {17'd0, lane_enable}, lane_m);
        chk("ev_freq", {22'd0, sound_freq}, freq_m);
        if (lives_m != 0) begin
            run_buz();
            chk("ev_over_clear", {31'd0, game_over}, 32'd0);
        end else begin
            step();
            chk("game_over_set", {31'd0, game_over}, 32'd1);
            chk("over_sound", {31'd0, enable_sound}, 32'd0);
        end
    endtask

    initial begin
        int takes;
        ev_t e;

        //          obj    pl    haz    goal   gate   sel    ev      gid
        vecs[0] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 4'd0, 3'b000, 3'd0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 4'd9, 3'b000, 3'd0};
        vecs[2] = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 4'd8, 3'b000, 3'd0};
        vecs[3] = '{8'h81, 1'b1, 8'h00, 8'h00, 8'h00, 4'd1, 3'b000, 3'd0};
        vecs[4] = '{8'h0C, 1'b0, 8'h04, 8'h00, 8'h00, 4'd3, 3'b000, 3'd0};
        vecs[5] = '{8'h10, 1'b1, 8'h00, 8'h00, 8'h10, 4'd5, 3'b001, 3'd4};
        vecs[6] = '{8'h30, 1'b1, 8'h00, 8'h00, 8'h20, 4'd5, 3'b000, 3'd0};
        vecs[7] = '{8'h02, 1'b1, 8'h00, 8'h00, 8'h02, 4'd2, 3'b001, 3'd1};
        vecs[8] = '{8'h40, 1'b1, 8'h00, 8'h00, 8'hFF, 4'd7, 3'b001, 3'd6};
        vecs[9] = '{8'h01, 1'b1, 8'h00, 8'h00, 8'h01, 4'd1, 3'b001, 3'd0};

        pause = 1'b0;
        clear_in();
        resetN = 1'b0;
        repeat (2) step();
        chk_reset_vals("init");
        chk("init_select_mux", {28'd0, select_mux}, 32'd0);
        resetN = 1'b1;
        model_reset();
        step();

        // Layer priority and gate takes, one frame per vector.
        for (int i = 0; i < 10; i++) begin
            frame_start = 1'b1;
            step();
            frame_start     = 1'b0;
            obj_draw_req    = vecs[i].obj;
            player_draw_req = vecs[i].pl;
            hazard_mask     = vecs[i].hz;
            goal_mask       = vecs[i].gl;
            gate_mask       = vecs[i].gt;
            #1;
            chk("vec_select_mux", {28'd0, select_mux}, {28'd0, vecs[i].sel});
            if (vecs[i].ev != 3'b000) begin
                e.flags = vecs[i].ev;
                e.gid   = vecs[i].gid;
                exp_q.push_back(e);
            end
            step();
            clear_in();
        end
        chk("table_status_level", {24'd0, level}, 32'd1);

        // Hazard on object 2: lose, lives 3 -> 2, lanes stay empty.
        do_event(1'b0, 2);
        chk("t1_lives", {28'd0, lives}, 32'd2);
        chk("t1_lane", {17'd0, lane_enable}, 32'd0);

        // Goal at level 1.
        do_event(1'b1, 3);
        chk("t2_level", {24'd0, level}, 32'd2);
        chk("t2_lane", {17'd0, lane_enable}, 32'h001F);

        // Wins up to three in total, then one lose.
        do_event(1'b1, 3);
        do_event(1'b1, 3);
        chk("t3_level_win", {24'd0, level}, 32'd4);
        chk("t3_lane_win", {17'd0, lane_enable}, 32'h7FFF);
        do_event(1'b0, 0);
        chk("t3_level_lose", {24'd0, level}, 32'd3);
        chk("t3_lane_lose", {17'd0, lane_enable}, 32'h03FF);
        for (int k = 0; k < 6; k++) do_event(1'b1, 6);
        chk("t3_level_max", {24'd0, level}, 32'd8);
        chk("t3_lane_max", {17'd0, lane_enable}, 32'h7FFF);

        // Gate held for many pixels: one take per frame.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int f = 0; f < 2; f++) begin
            takes = 0;
            obj_draw_req    = 8'h20;
            player_draw_req = 1'b1;
            gate_mask       = 8'h20;
            e.flags = 3'b001;
            e.gid   = 3'd5;
            exp_q.push_back(e);
            for (int c = 0; c < 6; c++) begin
                step();
                if (take_gate) takes++;
            end
            chk("gate_takes_per_frame", takes, 1);
            clear_in();
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end

        // Lose every life, hits ignored in game over, then restart.
        do_reset();
        do_event(1'b0, 1);
        do_event(1'b0, 1);
        do_event(1'b0, 1);
        obj_draw_req    = 8'h03;
        player_draw_req = 1'b1;
        hazard_mask     = 8'h01;
        goal_mask       = 8'h02;
        repeat (3) step();
        clear_in();
        chk("over_hold", {31'd0, game_over}, 32'd1);
        chk("over_lives", {28'd0, lives}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_over", {31'd0, game_over}, 32'd0);
        chk("restart_level", {24'd0, level}, 32'd1);
        chk("restart_lives", {28'd0, lives}, 32'd3);
        chk("restart_lane", {17'd0, lane_enable}, 32'd0);
        model_reset();
        step();

        // Asynchronous reset in the middle of a burst.
        obj_draw_req    = 8'h04;
        player_draw_req = 1'b1;
        goal_mask       = 8'h04;
        e.flags = 3'b100;
        e.gid   = 3'd0;
        exp_q.push_back(e);
        step();
        clear_in();
        repeat (3) step();
        chk("midbuz_sound_before", {31'd0, enable_sound}, 32'd1);
        resetN = 1'b0;
        #1;
        chk_reset_vals("midbuz");
        step();
        resetN = 1'b1;
        model_reset();
        step();

`ifdef GAME_PAUSE_EN
        // Pause mid-burst: sound gated off, burst stretched by the pause.
        begin
            int hi;
            int guard;
            obj_draw_req    = 8'h04;
            player_draw_req = 1'b1;
            goal_mask       = 8'h04;
            e.flags = 3'b100;
            e.gid   = 3'd0;
            exp_q.push_back(e);
            step();
            clear_in();
            step();
            hi = 0;
            repeat (2) begin
                if (enable_sound) hi++;
                step();
            end
            pause = 1'b1;
            #1;
            chk("pause_sound_off", {31'd0, enable_sound}, 32'd0);
            repeat (3) step();
            chk("pause_level_hold", {24'd0, level}, 32'd2);
            pause = 1'b0;
            #1;
            guard = 0;
            while (enable_sound && guard < 20) begin
                hi++;
                step();
                guard++;
            end
            chk("pause_buz_length", hi, BUZ);
        end
`endif

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
